// File: rtl/sigma_pkg.sv
// Shared SigmaCore definitions used by the multicycle control FSM and
// the ALU operation sub-decoder.
package sigma_pkg;

  localparam int unsigned STATE_W    = 5;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned IMM_TYPE_W = 3;
  localparam int unsigned SRC_W      = 2;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned FUNCT7_W   = 7;

  // Five bits are needed because the branch state sits at 16.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH         = 5'd0,
    S_DECODE        = 5'd1,
    S_MEM_ADDR_COMP = 5'd2,
    S_MEM_READ      = 5'd3,
    S_WB_MEM        = 5'd4,
    S_MEM_WRITE     = 5'd5,
    S_EXEC_R_TYPE   = 5'd6,
    S_WB_R_TYPE     = 5'd7,
    S_EXEC_R_LOG    = 5'd8,
    S_WB_R_LOG      = 5'd9,
    S_EXEC_R_SLT    = 5'd10,
    S_WB_R_SLT      = 5'd11,
    S_EXEC_R_SHIFT  = 5'd12,
    S_WB_R_SHIFT    = 5'd13,
    S_EXEC_I_TYPE   = 5'd14,
    S_WB_I_TYPE     = 5'd15,
    S_BRANCH        = 5'd16,
    S_HALT          = 5'd17
  } sigma_mc_state_t;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD    = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB    = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND    = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR     = 4'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR    = 4'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT    = 4'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL    = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL    = 4'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA    = 4'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_COPY_B = 4'd9;

  localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_NONE = 3'd0;
  localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_I    = 3'd1;
  localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_S    = 3'd2;
  localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_B    = 3'd3;
  localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_U    = 3'd4;
  localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_J    = 3'd5;

  localparam logic [SRC_W-1:0] ALU_SRC_A_PC     = 2'b00;
  localparam logic [SRC_W-1:0] ALU_SRC_A_OLD_PC = 2'b01;
  localparam logic [SRC_W-1:0] ALU_SRC_A_RS1    = 2'b10;

  localparam logic [SRC_W-1:0] ALU_SRC_B_RS2    = 2'b00;
  localparam logic [SRC_W-1:0] ALU_SRC_B_IMM    = 2'b01;
  localparam logic [SRC_W-1:0] ALU_SRC_B_FOUR   = 2'b10;

  localparam logic [SRC_W-1:0] RESULT_SRC_ALUOUT     = 2'b00;
  localparam logic [SRC_W-1:0] RESULT_SRC_MEM_DATA   = 2'b01;
  localparam logic [SRC_W-1:0] RESULT_SRC_ALU_RESULT = 2'b10;

  localparam logic [OPCODE_W-1:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPCODE_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPCODE_BRANCH = 7'b1100011;
  // Reserved for a future jump path; not decoded yet.
  localparam logic [OPCODE_W-1:0] OPCODE_JAL    = 7'b1101111;

  localparam logic [FUNCT7_W-1:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [FUNCT7_W-1:0] FUNCT7_ALT  = 7'b0100000;

endpackage

// File: rtl/sigma_alu_decoder.sv
// Combinational ALU operation decoder for R-type and OP-IMM instructions.
// Produces the ALU code plus a legality flag for the (funct3, funct7) pair.
module sigma_alu_decoder
  import sigma_pkg::*;
(
  input  logic [FUNCT3_W-1:0]   i_funct3,
  input  logic [FUNCT7_W-1:0]   i_funct7,
  input  logic                  i_is_rtype,
  output logic [ALU_CTRL_W-1:0] o_alu_control_c,
  output logic                  o_legal_c
);

  logic w_alt;
  logic w_base;

  assign w_alt  = (i_funct7 == FUNCT7_ALT);
  assign w_base = (i_funct7 == FUNCT7_BASE);

  // funct3 selects the operation; funct7 only matters for SUB/SRA and R-type legality
  always_comb begin
    o_alu_control_c = ALU_ADD;
    o_legal_c       = 1'b1;
    case (i_funct3)
      3'b000: o_alu_control_c = (i_is_rtype && w_alt) ? ALU_SUB : ALU_ADD;
      3'b001: o_alu_control_c = ALU_SLL;
      3'b010: o_alu_control_c = ALU_SLT;
      3'b011: o_legal_c       = 1'b0;
      3'b100: o_alu_control_c = ALU_XOR;
      3'b101: o_alu_control_c = w_alt ? ALU_SRA : ALU_SRL;
      3'b110: o_alu_control_c = ALU_OR;
      3'b111: o_alu_control_c = ALU_AND;
    endcase
    if (i_is_rtype && !(w_base || (w_alt && ((i_funct3 == 3'b000) || (i_funct3 == 3'b101))))) begin
      o_legal_c = 1'b0;
    end
  end

endmodule

// File: rtl/sigma_mc_control.sv
// Multicycle main control FSM for the SigmaCore RV32I datapath.
// Outputs are decoded from the current state (FETCH and memory strobes are
// additionally qualified by mem_ready) and forced inactive while rst_n=0.
// Build option SIGMA_MC_ILLEGAL_TRAP_EN: an illegal instruction parks the
// FSM in S_HALT until reset; otherwise it behaves as a NOP.
module sigma_mc_control
  import sigma_pkg::*;
#(
  parameter sigma_mc_state_t RESET_STATE = S_FETCH,
  parameter bit              MEM_WAIT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [FUNCT3_W-1:0]   funct3,
  input  logic [FUNCT7_W-1:0]   funct7,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic                  ir_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [SRC_W-1:0]      alu_src_a,
  output logic [SRC_W-1:0]      alu_src_b,
  output logic [SRC_W-1:0]      result_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [IMM_TYPE_W-1:0] imm_type,
  output logic [STATE_W-1:0]    state_o,
  output logic                  illegal_instr
);

`ifdef SIGMA_MC_ILLEGAL_TRAP_EN
  localparam sigma_mc_state_t ILLEGAL_NEXT = S_HALT;
`else
  localparam sigma_mc_state_t ILLEGAL_NEXT = S_FETCH;
`endif

  sigma_mc_state_t r_state;
  sigma_mc_state_t w_next;

  logic                  w_mem_ready;
  logic                  w_legal;
  logic                  w_dec_legal;
  logic [ALU_CTRL_W-1:0] w_dec_alu;
  logic                  w_unused;

  // Branch resolution on zero happens in the datapath, not here.
  assign w_unused    = zero;
  assign w_mem_ready = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state_o     = r_state;

  sigma_alu_decoder u_alu_dec (
    .i_funct3        (funct3),
    .i_funct7        (funct7),
    .i_is_rtype      (opcode == OPCODE_RTYPE),
    .o_alu_control_c (w_dec_alu),
    .o_legal_c       (w_dec_legal)
  );

  // Instruction legality check used in DECODE
  always_comb begin
    w_legal = 1'b0;
    case (opcode)
      OPCODE_LUI:                 w_legal = 1'b1;
      OPCODE_IMM, OPCODE_RTYPE:   w_legal = w_dec_legal;
      OPCODE_LOAD, OPCODE_STORE:  w_legal = (funct3 == 3'b010);
      OPCODE_BRANCH:              w_legal = (funct3 == 3'b000);
      default:                    w_legal = 1'b0;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_next        = r_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = ALU_SRC_A_PC;
    alu_src_b     = ALU_SRC_B_RS2;
    result_src    = RESULT_SRC_ALUOUT;
    alu_control   = ALU_ADD;
    imm_type      = IMM_TYPE_NONE;
    illegal_instr = 1'b0;

    case (r_state)
      S_FETCH: begin
        alu_src_b  = ALU_SRC_B_FOUR;
        result_src = RESULT_SRC_ALU_RESULT;
        ir_write   = w_mem_ready;
        pc_write   = w_mem_ready;
        if (w_mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = ALU_SRC_A_OLD_PC;
        alu_src_b = ALU_SRC_B_IMM;
        imm_type  = IMM_TYPE_B;
        if (!w_legal) begin
          illegal_instr = 1'b1;
          w_next        = ILLEGAL_NEXT;
        end else begin
          case (opcode)
            OPCODE_LOAD, OPCODE_STORE: w_next = S_MEM_ADDR_COMP;
            OPCODE_IMM, OPCODE_LUI:    w_next = S_EXEC_I_TYPE;
            OPCODE_BRANCH:             w_next = S_BRANCH;
            OPCODE_RTYPE: begin
              case (funct3)
                3'b000:         w_next = S_EXEC_R_TYPE;
                3'b010, 3'b011: w_next = S_EXEC_R_SLT;
                3'b001, 3'b101: w_next = S_EXEC_R_SHIFT;
                default:        w_next = S_EXEC_R_LOG;
              endcase
            end
            default:                   w_next = ILLEGAL_NEXT;
          endcase
        end
      end
      S_MEM_ADDR_COMP: begin
        alu_src_a = ALU_SRC_A_RS1;
        alu_src_b = ALU_SRC_B_IMM;
        imm_type  = (opcode == OPCODE_STORE) ? IMM_TYPE_S : IMM_TYPE_I;
        w_next    = (opcode == OPCODE_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src = 1'b1;
        if (w_mem_ready) w_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        result_src = RESULT_SRC_MEM_DATA;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = w_mem_ready;
        if (w_mem_ready) w_next = S_FETCH;
      end
      S_EXEC_R_TYPE, S_EXEC_R_LOG, S_EXEC_R_SLT, S_EXEC_R_SHIFT: begin
        alu_src_a   = ALU_SRC_A_RS1;
        alu_src_b   = ALU_SRC_B_RS2;
        alu_control = w_dec_alu;
        case (r_state)
          S_EXEC_R_LOG:   w_next = S_WB_R_LOG;
          S_EXEC_R_SLT:   w_next = S_WB_R_SLT;
          S_EXEC_R_SHIFT: w_next = S_WB_R_SHIFT;
          default:        w_next = S_WB_R_TYPE;
        endcase
      end
      S_WB_R_TYPE, S_WB_R_LOG, S_WB_R_SLT, S_WB_R_SHIFT, S_WB_I_TYPE: begin
        result_src = RESULT_SRC_ALUOUT;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXEC_I_TYPE: begin
        alu_src_b = ALU_SRC_B_IMM;
        if (opcode == OPCODE_LUI) begin
          imm_type    = IMM_TYPE_U;
          alu_control = ALU_COPY_B;
        end else begin
          alu_src_a   = ALU_SRC_A_RS1;
          imm_type    = IMM_TYPE_I;
          alu_control = w_dec_alu;
        end
        w_next = S_WB_I_TYPE;
      end
      S_BRANCH: begin
        alu_src_a     = ALU_SRC_A_RS1;
        alu_src_b     = ALU_SRC_B_RS2;
        alu_control   = ALU_SUB;
        result_src    = RESULT_SRC_ALUOUT;
        pc_write_cond = 1'b1;
        w_next        = S_FETCH;
      end
      S_HALT: begin
        illegal_instr = 1'b1;
        w_next        = S_HALT;
      end
      default: w_next = RESET_STATE;
    endcase

    // No control strobe may fire while reset is held.
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      adr_src       = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = ALU_SRC_A_PC;
      alu_src_b     = ALU_SRC_B_RS2;
      result_src    = RESULT_SRC_ALUOUT;
      alu_control   = ALU_ADD;
      imm_type      = IMM_TYPE_NONE;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_sigma_mc_control.sv
// Scoreboard bench for sigma_mc_control: an instruction-level reference
// model expands each instruction into its expected per-cycle control
// pattern, and a monitor compares the DUT against it every cycle.
module tb_sigma_mc_control;
  import sigma_pkg::*;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  typedef struct packed {
    logic       pcw, pcwc, irw, adr, mw, rw;
    logic [1:0] sa, sb, rs;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       ill;
  } outs_t;

  typedef struct packed {
    outs_t o;
    int    st;   // -1: state encoding not checked this cycle
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;

  logic       pc_write, pc_write_cond, ir_write, adr_src, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_control;
  logic [2:0] imm_type;
  logic [4:0] state_o;
  logic       illegal_instr;

  logic [6:0] n_op;
  logic [2:0] n_f3;
  logic [6:0] n_f7;

  exp_t  exp_q[$];
  exp_t  mon_e;
  outs_t act;
  int    n_checks = 0;
  int    n_fail = 0;

  sigma_mc_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .result_src    (result_src),
    .alu_control   (alu_control),
    .imm_type      (imm_type),
    .state_o       (state_o),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, pc_write_cond, ir_write, adr_src, mem_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_control, imm_type, illegal_instr};

  // Monitor: every cycle with a pending expectation is compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (act !== mon_e.o) begin
        n_fail++;
        $display("FAIL outputs t=%0t op=%h f3=%h f7=%h got=%h expected=%h",
                 $time, opcode, funct3, funct7, act, mon_e.o);
      end
      if (mon_e.st >= 0) begin
        n_checks++;
        if (state_o !== 5'(mon_e.st)) begin
          n_fail++;
          $display("FAIL state_o t=%0t got=%0d expected=%0d", $time, state_o, mon_e.st);
        end
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic outs_t od();
    outs_t o;
    o     = '0;
    o.alu = ALU_ADD;
    o.imm = IMM_TYPE_NONE;
    return o;
  endfunction

  // Legal instruction set, straight from the ISA subset rules
  function automatic bit legal_ref(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    case (op)
      OP_LUI:              return 1'b1;
      OP_IMM:              return f3 != 3'd3;
      OP_RTYPE:            return (f3 != 3'd3) &&
                                  ((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      OP_LOAD, OP_STORE:   return f3 == 3'd2;
      OP_BRANCH:           return f3 == 3'd0;
      default:             return 1'b0;
    endcase
  endfunction

  // RV32I operation named by funct3/funct7
  function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic [6:0] f7, input bit is_r);
    case (f3)
      3'd0:    return (is_r && f7 == 7'h20) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd4:    return ALU_XOR;
      3'd5:    return (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      3'd7:    return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  // Drive one cycle of inputs and post its expected outputs
  task automatic cyc(input logic rst, input logic mr, input bit ld, input outs_t o, input int st);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rst;
    mem_ready = mr;
    zero      = rb();
    if (ld) begin
      opcode = n_op;
      funct3 = n_f3;
      funct7 = n_f7;
    end
    e.o  = o;
    e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, rb(), 1'b0, od(), (i == 0) ? -1 : 0);
  endtask

  // Expand one instruction into its expected cycle sequence
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int wf, input int wm, input int abort_rd);
    outs_t o;
    bit    lg;
    lg   = legal_ref(op, f3, f7);
    n_op = op;
    n_f3 = f3;
    n_f7 = f7;

    o = od(); o.sb = 2'b10; o.rs = 2'b10;
    for (int i = 0; i < wf; i++) cyc(1'b1, 1'b0, i == 0, o, 0);
    o.irw = 1'b1; o.pcw = 1'b1;
    cyc(1'b1, 1'b1, wf == 0, o, 0);

    o = od(); o.sa = 2'b01; o.sb = 2'b01; o.imm = IMM_TYPE_B; o.ill = !lg;
    cyc(1'b1, rb(), 1'b0, o, -1);

    if (!lg) begin
`ifdef SIGMA_MC_ILLEGAL_TRAP_EN
      o = od(); o.ill = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1'b1, rb(), 1'b0, o, 17);
      do_reset(2);
`endif
      return;
    end

    case (op)
      OP_LOAD, OP_STORE: begin
        o = od(); o.sa = 2'b10; o.sb = 2'b01;
        o.imm = (op == OP_STORE) ? IMM_TYPE_S : IMM_TYPE_I;
        cyc(1'b1, rb(), 1'b0, o, -1);
        o = od(); o.adr = 1'b1;
        if (abort_rd >= 0) begin
          for (int i = 0; i < abort_rd; i++) cyc(1'b1, 1'b0, 1'b0, o, -1);
          do_reset(2);
          return;
        end
        for (int i = 0; i < wm; i++) cyc(1'b1, 1'b0, 1'b0, o, -1);
        if (op == OP_STORE) begin
          o.mw = 1'b1;
          cyc(1'b1, 1'b1, 1'b0, o, -1);
        end else begin
          cyc(1'b1, 1'b1, 1'b0, o, -1);
          o = od(); o.rs = 2'b01; o.rw = 1'b1;
          cyc(1'b1, rb(), 1'b0, o, -1);
        end
      end
      OP_BRANCH: begin
        o = od(); o.sa = 2'b10; o.alu = ALU_SUB; o.pcwc = 1'b1;
        cyc(1'b1, rb(), 1'b0, o, 16);
      end
      default: begin
        o = od();
        if (op == OP_LUI) begin
          o.sb = 2'b01; o.imm = IMM_TYPE_U; o.alu = ALU_COPY_B;
        end else if (op == OP_IMM) begin
          o.sa = 2'b10; o.sb = 2'b01; o.imm = IMM_TYPE_I; o.alu = alu_ref(f3, f7, 1'b0);
        end else begin
          o.sa = 2'b10; o.alu = alu_ref(f3, f7, 1'b1);
        end
        cyc(1'b1, rb(), 1'b0, o, -1);
        o = od(); o.rw = 1'b1;
        cyc(1'b1, rb(), 1'b0, o, -1);
      end
    endcase
  endtask

  task automatic run_word(input logic [31:0] w, input int wf, input int wm, input int abort_rd);
    run_instr(w[6:0], w[14:12], w[31:25], wf, wm, abort_rd);
  endtask

  task automatic run_random(input int n);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         c;
    for (int k = 0; k < n; k++) begin
      c = int'($urandom_range(0, 9));
      case (c)
        0:       op = OP_LOAD;
        1:       op = OP_STORE;
        2, 3:    op = OP_RTYPE;
        4, 5:    op = OP_IMM;
        6:       op = OP_LUI;
        7:       op = OP_BRANCH;
        8:       op = 7'($urandom);
        default: op = 7'h7F;
      endcase
      f3 = 3'($urandom);
      if ((op == OP_LOAD || op == OP_STORE) && $urandom_range(0, 3) != 0) f3 = 3'd2;
      if (op == OP_BRANCH && $urandom_range(0, 3) != 0) f3 = 3'd0;
      c = int'($urandom_range(0, 3));
      f7 = (c < 2) ? 7'h00 : (c == 2) ? 7'h20 : 7'($urandom);
      run_instr(op, f3, f7, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                int'($urandom_range(0, 3)), -1);
    end
  endtask

  initial begin
    do_reset(2);
    run_word(32'h002081B3, 0, 0, -1);   // add x3,x1,x2
    run_word(32'h00802283, 1, 3, -1);   // lw x5,8(x0), three wait cycles
    run_word(32'h00502623, 0, 2, -1);   // sw x5,12(x0)
    run_word(32'h00000463, 0, 0, -1);   // beq x0,x0,8
    run_word(32'h123450B7, 2, 0, -1);   // lui x1,0x12345
    run_word(32'h00802283, 0, 0, 2);    // lw interrupted by reset in MEM_READ
    run_word(32'h0000007F, 0, 0, -1);   // unsupported opcode
    run_word(32'h40208133, 0, 0, -1);   // sub
    run_word(32'h4020D133, 0, 0, -1);   // sra
    run_word(32'h4020C133, 0, 0, -1);   // xor with funct7 alt: illegal
    run_word(32'h0020B133, 0, 0, -1);   // sltu: illegal
    run_word(32'h4030D093, 0, 0, -1);   // srai
    run_random(300);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
